mem_stage_access: RTL and testbench

- Memory-stage access unit of the pipelined RISC-V core. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the EX/MEM load/store request and runs it on a req/ack data-memory bus. Stalls the pipeline until the access completes or times out.
- Formats load data (byte/half extension) and store lanes. Drives the MEM/WB register's enable and ReadData input.

---
 rtl/mem_stage_access_pkg.sv | 28 ++
 rtl/mem_align_unit.sv | 52 +++++
 rtl/mem_stage_access.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_access.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_access_pkg.sv
// Shared definitions for the MEM-stage access unit: funct3 encodings, FSM states,
// default bus timeout and the alignment rule.
package mem_stage_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Size comes from funct3[1:0]; encodings 11 fall into the word rule.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~lo[0];
      default: is_aligned = (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane logic: store byte-enable/data steering, load extension and
// the alignment check, driven from one funct3/lane pair.
module mem_align_unit
  import mem_stage_access_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic        aligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign aligned_o = is_aligned(funct3_i, lane_i);
  assign shifted   = rdata_i >> {lane_i, 3'b000};
  assign byte_sel  = shifted[7:0];
  assign half_sel  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data_o = rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage load/store unit: issues one req/ack bus access per EX/MEM slot,
// stalls the pipeline until ack or timeout, and formats load data for MEM/WB.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [2:0]        funct3_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       store_data_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       read_data,
  output logic              stall,
  output logic              mem_wb_enable,
  output logic              misaligned,
  output logic              bus_error
);

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic              mis_q, mis_d, berr_q, berr_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        cnt_q, cnt_d;

  logic        start, in_wait;
  logic [2:0]  au_f3;
  logic [1:0]  au_lane;
  logic        au_aligned;
  logic [3:0]  au_be;
  logic [31:0] au_wdata, au_load;

  assign start   = valid_in & (mem_read_in | mem_write_in);
  assign in_wait = (state_q == S_WAIT);

  // The single lane unit sees the live request in IDLE and the latched one in WAIT.
  assign au_f3   = in_wait ? f3_q   : funct3_in;
  assign au_lane = in_wait ? lane_q : addr_in[1:0];

  mem_align_unit u_align (
    .funct3_i     (au_f3),
    .lane_i       (au_lane),
    .store_data_i (store_data_in),
    .rdata_i      (dmem_rdata),
    .aligned_o    (au_aligned),
    .be_o         (au_be),
    .wdata_o      (au_wdata),
    .load_data_o  (au_load)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    is_load_d     = is_load_q;
    f3_d          = f3_q;
    lane_d        = lane_q;
    cnt_d         = cnt_q;
    mis_d         = 1'b0;
    berr_d        = 1'b0;
    stall         = 1'b0;
    mem_wb_enable = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (au_aligned) begin
            req_d         = 1'b1;
            we_d          = mem_write_in;
            addr_d        = {addr_in[ADDR_W-1:2], 2'b00};
            be_d          = mem_write_in ? au_be : 4'b1111;
            wdata_d       = mem_write_in ? au_wdata : '0;
            is_load_d     = ~mem_write_in;
            f3_d          = funct3_in;
            lane_d        = addr_in[1:0];
            state_d       = S_WAIT;
            stall         = 1'b1;
            mem_wb_enable = 1'b0;
          end else begin
            mis_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_WAIT: begin
        stall         = 1'b1;
        mem_wb_enable = 1'b0;
        cnt_d         = cnt_q + 8'd1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (is_load_q) rdata_d = au_load;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          rdata_d = '0;
          berr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      is_load_q <= 1'b0;
      f3_q      <= '0;
      lane_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
      is_load_q <= is_load_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign read_data  = rdata_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: vector table of single accesses plus
// hand sequences for reset, mid-access reset, back-to-back and bus timeout.
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, store_data_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data;
  logic        stall, mem_wb_enable, misaligned, bus_error;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_access #(.TIMEOUT_CYCLES(255), .ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .funct3_in     (funct3_in),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .read_data     (read_data),
    .stall         (stall),
    .mem_wb_enable (mem_wb_enable),
    .misaligned    (misaligned),
    .bus_error     (bus_error)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int unsigned delay;
    logic        mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    valid_in = 0; mem_read_in = 0; mem_write_in = 0;
    funct3_in = 3'b010; addr_in = '0; store_data_in = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int unsigned stalls;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    valid_in = 1; mem_read_in = v.rd; mem_write_in = v.wr;
    funct3_in = v.f3; addr_in = v.addr; store_data_in = v.sdata;
    #1;
    if (v.mis) begin
      chk({tag, "_mis_stall"}, 32'(stall), 0);
      chk({tag, "_mis_wbe"}, 32'(mem_wb_enable), 1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk({tag, "_mis_pulse"}, 32'(misaligned), 1);
      chk({tag, "_mis_req"}, 32'(dmem_req), 0);
      chk({tag, "_mis_rdata"}, read_data, v.exp_rd);
      chk({tag, "_mis_stall2"}, 32'(stall), 0);
      @(negedge clk);
      chk({tag, "_mis_clear"}, 32'(misaligned), 0);
      return;
    end
    stalls = 32'(stall);
    @(negedge clk);
    chk({tag, "_req"}, 32'(dmem_req), 1);
    chk({tag, "_we"}, 32'(dmem_we), 32'(v.wr));
    chk({tag, "_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
    chk({tag, "_be"}, 32'(dmem_be), 32'(v.exp_be));
    if (v.wr) chk({tag, "_wdata"}, dmem_wdata, v.exp_wdata);
    for (int k = 0; k < int'(v.delay); k++) begin
      stalls += 32'(stall);
      @(negedge clk);
      chk({tag, "_req_held"}, 32'(dmem_req), 1);
    end
    dmem_ack = 1; dmem_rdata = v.rdata;
    #1;
    stalls += 32'(stall);
    chk({tag, "_wbe_wait"}, 32'(mem_wb_enable), 0);
    @(negedge clk);
    dmem_ack = 0; dmem_rdata = 32'h5A5A5A5A;
    idle_inputs();
    #1;
    chk({tag, "_done_stall"}, 32'(stall), 0);
    chk({tag, "_done_wbe"}, 32'(mem_wb_enable), 1);
    chk({tag, "_done_req"}, 32'(dmem_req), 0);
    chk({tag, "_read_data"}, read_data, v.exp_rd);
    chk({tag, "_stall_cycles"}, stalls, 2 + v.delay);
    chk({tag, "_no_berr"}, 32'(bus_error), 0);
  endtask

  initial begin
    int unsigned stalls;
    int unsigned waited;
    idle_inputs();
    dmem_ack = 0; dmem_rdata = '0; reset = 0;

    //                rd wr  f3       addr          sdata         rdata         dly mis be       wdata         exp read_data
    vecs.push_back('{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0, 0, 4'b1111, 32'h0,        32'hFFFFFF80});
    vecs.push_back('{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 1, 0, 4'b1111, 32'h0,        32'h00000080});
    vecs.push_back('{1, 0, 3'b101, 32'h102, 32'h0,        32'h80FF1234, 0, 0, 4'b1111, 32'h0,        32'h000080FF});
    vecs.push_back('{1, 0, 3'b001, 32'h102, 32'h0,        32'h80FF1234, 0, 0, 4'b1111, 32'h0,        32'hFFFF80FF});
    vecs.push_back('{1, 0, 3'b000, 32'h101, 32'h0,        32'h12345678, 0, 0, 4'b1111, 32'h0,        32'h00000056});
    vecs.push_back('{1, 0, 3'b001, 32'h200, 32'h0,        32'h1234F00D, 2, 0, 4'b1111, 32'h0,        32'hFFFFF00D});
    vecs.push_back('{0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 0, 4'b0010, 32'hA5A5A5A5, 32'hFFFFF00D});
    vecs.push_back('{0, 1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEFBEEF, 32'hFFFFF00D});
    vecs.push_back('{0, 1, 3'b001, 32'h104, 32'h00005566, 32'h0,        1, 0, 4'b0011, 32'h55665566, 32'hFFFFF00D});
    vecs.push_back('{1, 1, 3'b010, 32'h108, 32'h11223344, 32'hFFFFFFFF, 2, 0, 4'b1111, 32'h11223344, 32'hFFFFF00D});
    vecs.push_back('{1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h00000000});
    vecs.push_back('{1, 0, 3'b010, 32'h10C, 32'h0,        32'h0BADF00D, 3, 0, 4'b1111, 32'h0,        32'h0BADF00D});
    vecs.push_back('{0, 1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h00000000});
    vecs.push_back('{1, 0, 3'b011, 32'h120, 32'h0,        32'hC0FFEE00, 0, 0, 4'b1111, 32'h0,        32'hC0FFEE00});

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", 32'(dmem_be), 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wbe", 32'(mem_wb_enable), 1);
    chk("rst_mis", 32'(misaligned), 0);
    chk("rst_berr", 32'(bus_error), 0);
    reset = 1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset during WAIT abandons the access
    @(negedge clk);
    valid_in = 1; mem_read_in = 1; funct3_in = 3'b010; addr_in = 32'h300;
    @(negedge clk);
    chk("rstw_req_before", 32'(dmem_req), 1);
    reset = 0;
    idle_inputs();
    @(negedge clk);
    chk("rstw_req", 32'(dmem_req), 0);
    chk("rstw_addr", dmem_addr, 0);
    chk("rstw_be", 32'(dmem_be), 0);
    chk("rstw_read_data", read_data, 0);
    chk("rstw_stall", 32'(stall), 0);
    chk("rstw_wbe", 32'(mem_wb_enable), 1);
    reset = 1;

    // Back-to-back load then store after the reset
    run_vec('{1, 0, 3'b010, 32'h040, 32'h0, 32'hCAFEBABE, 0, 0, 4'b1111, 32'h0, 32'hCAFEBABE}, 100);
    run_vec('{0, 1, 3'b000, 32'h043, 32'h0000007E, 32'h0, 0, 0, 4'b1000, 32'h7E7E7E7E, 32'hCAFEBABE}, 101);

    // Timeout: 255 WAIT cycles without ack
    @(negedge clk);
    valid_in = 1; mem_read_in = 1; funct3_in = 3'b010; addr_in = 32'h400;
    #1;
    stalls = 32'(stall);
    waited = 0;
    @(negedge clk);
    while (!bus_error && waited < 400) begin
      stalls += 32'(stall);
      waited++;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("to_berr", 32'(bus_error), 1);
    chk("to_stall_cycles", stalls, 256);
    chk("to_read_data", read_data, 0);
    chk("to_req", 32'(dmem_req), 0);
    chk("to_stall_done", 32'(stall), 0);
    chk("to_wbe_done", 32'(mem_wb_enable), 1);
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("to_berr_clear", 32'(bus_error), 0);
    @(negedge clk);
    dmem_ack = 0;
    #1;
    chk("late_ack_read_data", read_data, 0);
    chk("late_ack_req", 32'(dmem_req), 0);
    chk("late_ack_stall", 32'(stall), 0);
    chk("late_ack_berr", 32'(bus_error), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
